// File: rtl/dividi_pkg.sv
// Shared types for the sequential restoring divider.
package dividi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/dividi_paso.sv
// One restoring-division step: shift {rem,quo} left, trial-subtract D, restore on borrow.
module dividi_paso #(
  parameter int tamano = 16
) (
  input  logic [tamano:0]   rem_i,
  input  logic [tamano-1:0] quo_i,
  input  logic [tamano-1:0] d_i,
  output logic [tamano:0]   rem_o,
  output logic [tamano-1:0] quo_o
);

  logic [tamano+1:0] rem_sh_s;
  logic [tamano+1:0] trial_s;

  // Shift in the next dividend bit, then keep the difference only if it did not borrow
  always_comb begin
    rem_sh_s = {rem_i, quo_i[tamano-1]};
    // rem_i < D keeps both operands below 2^(T+1), so bit T+1 is a valid sign
    trial_s  = rem_sh_s - {2'b00, d_i};
    quo_o    = {quo_i[tamano-2:0], 1'b0};
    if (trial_s[tamano+1] == 1'b0) begin
      rem_o    = trial_s[tamano:0];
      quo_o[0] = 1'b1;
    end else begin
      rem_o    = rem_sh_s[tamano:0];
    end
  end

endmodule

// File: rtl/dividi.sv
// Sequential unsigned divider: 2T-bit dividend / T-bit divisor, one quotient bit per clock,
// with START / END_DIV one-shot handshake and zero-divisor / overflow flags.
module dividi
  import dividi_pkg::*;
#(
  parameter int tamano = 16
) (
  input  logic                  CLOCK,
  input  logic                  RESET,
  input  logic                  START,
  input  logic [2*tamano-1:0]   N,
  input  logic [tamano-1:0]     D,
  output logic [tamano-1:0]     Q,
  output logic [tamano-1:0]     R,
  output logic                  BUSY,
  output logic                  END_DIV,
  output logic                  DIV_ZERO,
  output logic                  OVF
);

  localparam int              CW   = $clog2(tamano) + 1;
  localparam logic [CW-1:0]   LAST = CW'(tamano - 1);
  localparam logic [CW-1:0]   ONE  = CW'(1);

  div_state_t          state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [tamano:0]     rem_q, rem_d;
  logic [tamano-1:0]   quo_q, quo_d;
  logic [tamano-1:0]   dv_q, dv_d;
  logic [tamano-1:0]   q_q, q_d;
  logic [tamano-1:0]   r_q, r_d;
  logic                busy_q, busy_d;
  logic                end_q, end_d;
  logic                dz_q, dz_d;
  logic                ovf_q, ovf_d;

  logic [tamano:0]     step_rem_s;
  logic [tamano-1:0]   step_quo_s;

  dividi_paso #(.tamano(tamano)) u_paso (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .d_i   (dv_q),
    .rem_o (step_rem_s),
    .quo_o (step_quo_s)
  );

  // Next-state, datapath and registered-output logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dv_d    = dv_q;
    q_d     = q_q;
    r_d     = r_q;
    busy_d  = busy_q;
    end_d   = 1'b0;
    dz_d    = dz_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (START) begin
          dv_d  = D;
          dz_d  = 1'b0;
          ovf_d = 1'b0;
          if (D == {tamano{1'b0}}) begin
            dz_d    = 1'b1;
            q_d     = {tamano{1'b1}};
            r_d     = {tamano{1'b0}};
            end_d   = 1'b1;
            state_d = DONE;
          end else if (N[2*tamano-1:tamano] >= D) begin
            // Upper half >= D means the quotient needs more than T bits
            ovf_d   = 1'b1;
            q_d     = {tamano{1'b1}};
            r_d     = {tamano{1'b0}};
            end_d   = 1'b1;
            state_d = DONE;
          end else begin
            rem_d   = {1'b0, N[2*tamano-1:tamano]};
            quo_d   = N[tamano-1:0];
            cnt_d   = {CW{1'b0}};
            busy_d  = 1'b1;
            state_d = CALC;
          end
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        rem_d = step_rem_s;
        quo_d = step_quo_s;
        cnt_d = cnt_q + ONE;
        if (cnt_q == LAST) begin
          q_d     = step_quo_s;
          r_d     = step_rem_s[tamano-1:0];
          busy_d  = 1'b0;
          end_d   = 1'b1;
          state_d = DONE;
        end else begin
          state_d = CALC;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and result registers
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= {CW{1'b0}};
      rem_q   <= {(tamano+1){1'b0}};
      quo_q   <= {tamano{1'b0}};
      dv_q    <= {tamano{1'b0}};
      q_q     <= {tamano{1'b0}};
      r_q     <= {tamano{1'b0}};
      busy_q  <= 1'b0;
      end_q   <= 1'b0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dv_q    <= dv_d;
      q_q     <= q_d;
      r_q     <= r_d;
      busy_q  <= busy_d;
      end_q   <= end_d;
      dz_q    <= dz_d;
      ovf_q   <= ovf_d;
    end
  end

  assign Q        = q_q;
  assign R        = r_q;
  assign BUSY     = busy_q;
  assign END_DIV  = end_q;
  assign DIV_ZERO = dz_q;
  assign OVF      = ovf_q;

endmodule

// File: tb/tb_dividi.sv
// Scoreboard bench for dividi: an 8-bit and a 16-bit instance share clock and reset;
// expectations come from plain integer division in the bench.
module tb_dividi;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        s8, s16;
  logic [15:0] n8;
  logic [7:0]  d8, q8, r8;
  logic        b8, e8, z8, o8;
  logic [31:0] n16;
  logic [15:0] d16, q16, r16;
  logic        b16, e16, z16, o16;

  dividi #(.tamano(8)) u8 (
    .CLOCK(clk), .RESET(rst), .START(s8), .N(n8), .D(d8), .Q(q8), .R(r8),
    .BUSY(b8), .END_DIV(e8), .DIV_ZERO(z8), .OVF(o8));

  dividi #(.tamano(16)) u16 (
    .CLOCK(clk), .RESET(rst), .START(s16), .N(n16), .D(d16), .Q(q16), .R(r16),
    .BUSY(b16), .END_DIV(e16), .DIV_ZERO(z16), .OVF(o16));

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    longint n;
    longint d;
    longint q;
    longint r;
    bit     dz;
    bit     ovf;
    int     at;
  } exp_t;

  exp_t sb8[$];
  exp_t sb16[$];

  // Reference: result by integer division; flagged results saturate Q and zero R.
  // 'at' is the sampling-edge index at which END_DIV is expected to be seen.
  function automatic exp_t model(int t, longint n, longint d, int edge_i);
    exp_t e;
    e.n = n; e.d = d; e.dz = 1'b0; e.ovf = 1'b0; e.q = 0; e.r = 0;
    if (d == 0) begin
      e.dz = 1'b1; e.q = (64'd1 << t) - 1; e.at = edge_i + 1;
    end else if (n / d >= (64'd1 << t)) begin
      e.ovf = 1'b1; e.q = (64'd1 << t) - 1; e.at = edge_i + 1;
    end else begin
      e.q = n / d; e.r = n % d; e.at = edge_i + t + 1;
    end
    return e;
  endfunction

  task automatic chk(string nm, longint act, longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Monitor for the 8-bit instance
  always @(negedge clk) begin
    exp_t e;
    if (!rst && e8 === 1'b1) begin
      if (sb8.size() == 0) begin
        chk("u8 unexpected END_DIV", 1, 0);
      end else begin
        e = sb8.pop_front();
        chk("u8 Q", q8, e.q);
        chk("u8 R", r8, e.r);
        chk("u8 DIV_ZERO", z8, e.dz);
        chk("u8 OVF", o8, e.ovf);
        chk("u8 BUSY at end", b8, 0);
        chk("u8 END_DIV edge", cyc + 1, e.at);
      end
    end
  end

  // Monitor for the 16-bit instance
  always @(negedge clk) begin
    exp_t e;
    if (!rst && e16 === 1'b1) begin
      if (sb16.size() == 0) begin
        chk("u16 unexpected END_DIV", 1, 0);
      end else begin
        e = sb16.pop_front();
        chk("u16 Q", q16, e.q);
        chk("u16 R", r16, e.r);
        chk("u16 flags", {z16, o16}, {e.dz, e.ovf});
        chk("u16 END_DIV edge", cyc + 1, e.at);
        if (!e.dz && !e.ovf) begin
          chk("u16 N==Q*D+R", longint'(q16) * e.d + longint'(r16), e.n);
          chk("u16 R<D", longint'(r16) < e.d, 1);
        end
      end
    end
  end

  task automatic start8(longint n, longint d, bit push);
    @(negedge clk);
    n8 = n[15:0]; d8 = d[7:0]; s8 = 1'b1;
    if (push) sb8.push_back(model(8, n, d, cyc + 1));
    @(negedge clk);
    s8 = 1'b0; n8 = 16'($urandom); d8 = 8'($urandom);
  endtask

  task automatic wait8();
    for (int i = 0; i < 40 && sb8.size() != 0; i++) @(negedge clk);
    if (sb8.size() != 0) begin
      chk("u8 END_DIV timeout", sb8.size(), 0);
      sb8.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic run16(longint n, longint d);
    @(negedge clk);
    n16 = n[31:0]; d16 = d[15:0]; s16 = 1'b1;
    sb16.push_back(model(16, n, d, cyc + 1));
    @(negedge clk);
    s16 = 1'b0; n16 = $urandom; d16 = 16'($urandom);
    for (int i = 0; i < 60 && sb16.size() != 0; i++) @(negedge clk);
    if (sb16.size() != 0) begin
      chk("u16 END_DIV timeout", sb16.size(), 0);
      sb16.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    longint hi, d;
    rst = 1'b1; s8 = 1'b0; s16 = 1'b0;
    n8 = 16'd0; d8 = 8'd0; n16 = 32'd0; d16 = 16'd0;
    repeat (3) @(negedge clk);
    chk("reset Q", q8, 0);
    chk("reset R", r8, 0);
    chk("reset BUSY", b8, 0);
    chk("reset END_DIV", e8, 0);
    chk("reset flags", {z8, o8}, 0);
    chk("reset u16 outputs", {q16, r16, b16, e16, z16, o16}, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    start8(15, 5, 1);
    chk("u8 BUSY in calc", b8, 1);
    wait8();
    start8(1000, 7, 1);  wait8();
    start8(30000, 150, 1); wait8();
    start8(65024, 255, 1); wait8();
    start8(100, 0, 1);   wait8();
    start8(512, 2, 1);   wait8();
    start8(255, 1, 1);   wait8();
    start8(256, 1, 1);   wait8();

    // START during CALC must be ignored
    start8(1000, 7, 1);
    repeat (2) @(negedge clk);
    n8 = 16'd50; d8 = 8'd0; s8 = 1'b1;
    @(negedge clk);
    s8 = 1'b0;
    wait8();

    // Reset mid-CALC aborts with no completion pulse
    start8(40000, 200, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid-calc reset outputs", {q8, r8, b8, e8, z8, o8}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    start8(1000, 7, 1); wait8();

    for (int i = 0; i < 60; i++) begin
      start8($urandom_range(65535, 0), $urandom_range(255, 0), 1);
      wait8();
    end

    run16(32'hFFFE_0001, 16'hFFFF);
    run16(32'h0001_0000, 16'h0001);
    run16(32'd12345, 16'd0);
    for (int i = 0; i < 1000; i++) begin
      d  = $urandom_range(65535, 1);
      hi = longint'($urandom) % d;
      run16((hi << 16) | longint'($urandom_range(65535, 0)), d);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
